// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment display path: active-low segment patterns
// ({g,f,e,d,c,b,a}), the all-off anode word and the slot-to-anode helper.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  typedef logic [1:0] slot_t;

  // Active-low one-cold anode word for a scan slot; slot 0 is the rightmost digit.
  function automatic logic [3:0] slot_anode(input slot_t s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
// Shared with the alarm/date display.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed HH:MM driver for a 4-digit common-anode display with
// leading-zero blanking, per-digit blink and decimal-point control.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 500
) (
  input  logic       clk,
  input  logic       ncr,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       lzb,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] ps_reg, ps_next;
  slot_t         sel_reg, sel_next;
  logic [BW-1:0] bc_reg, bc_next;
  logic          phase_reg, phase_next;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic          tick;

  logic [3:0] digit [NUM_DIGITS];
  logic [6:0] dec_seg [NUM_DIGITS];
  logic [3:0] blank_vec;

  assign digit[0] = d0;
  assign digit[1] = d1;
  assign digit[2] = d2;
  assign digit[3] = d3;

  // Every digit is decoded in parallel so the slot mux sits after the decoders.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_to_seg7 u_dec (
        .bcd (digit[gi]),
        .seg (dec_seg[gi])
      );
      if (gi == NUM_DIGITS - 1) begin : g_lead
        assign blank_vec[gi] = (blink_mask[gi] & phase_reg) | (lzb & (d3 == 4'd0));
      end else begin : g_other
        assign blank_vec[gi] = blink_mask[gi] & phase_reg;
      end
    end
  endgenerate

  assign tick = en && (ps_reg == PS_LAST);

  always_comb begin
    ps_next    = ps_reg;
    sel_next   = sel_reg;
    bc_next    = bc_reg;
    phase_next = phase_reg;
    if (en) begin
      ps_next = tick ? '0 : ps_reg + 1'b1;
    end
    if (tick) begin
      sel_next = sel_reg + 2'd1;
      if (bc_reg == BC_LAST) begin
        bc_next    = '0;
        phase_next = ~phase_reg;
      end else begin
        bc_next = bc_reg + 1'b1;
      end
    end
  end

  // Outputs are built from pre-edge sel/phase, so a slot change and a phase
  // toggle on the same edge take effect on the display one clock later.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (en && !blank_vec[sel_reg]) begin
      an_next  = slot_anode(sel_reg);
      seg_next = dec_seg[sel_reg];
      dp_next  = ~dp_mask[sel_reg];
    end
  end

  always_ff @(posedge clk or posedge ncr) begin
    if (ncr) begin
      ps_reg    <= '0;
      sel_reg   <= '0;
      bc_reg    <= '0;
      phase_reg <= 1'b0;
      an_reg    <= AN_OFF;
      seg_reg   <= SEG_OFF;
      dp_reg    <= 1'b1;
    end else begin
      ps_reg    <= ps_next;
      sel_reg   <= sel_next;
      bc_reg    <= bc_next;
      phase_reg <= phase_next;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: per-cycle expectations are queued
// from a behavioural model when inputs are driven and popped after each edge.
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       ncr = 1'b1;
  logic       en  = 1'b0;
  logic       lzb = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] blink_mask = '0, dp_mask = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .ncr        (ncr),
    .en         (en),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .lzb        (lzb),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam exp_t OFF = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_ps = 0, m_sel = 0, m_bc = 0;
  bit m_phase = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t       r;
    logic [3:0] dv;
    logic       blank;
    r  = OFF;
    dv = d0;
    if (en) begin
      case (m_sel)
        0: dv = d0;
        1: dv = d1;
        2: dv = d2;
        default: dv = d3;
      endcase
      blank = (blink_mask[m_sel] && m_phase) || (m_sel == 3 && lzb && d3 == 4'd0);
      if (!blank) begin
        r.an        = 4'b1111;
        r.an[m_sel] = 1'b0;
        r.seg       = ref_seg(dv);
        r.dp        = !dp_mask[m_sel];
      end
    end
    return r;
  endfunction

  task automatic model_advance();
    if (en) begin
      if (m_ps == SD - 1) begin
        m_ps  = 0;
        m_sel = (m_sel + 1) % 4;
        if (m_bc == BD - 1) begin
          m_bc    = 0;
          m_phase = !m_phase;
        end else begin
          m_bc++;
        end
      end else begin
        m_ps++;
      end
    end
  endtask

  task automatic model_reset();
    m_ps = 0; m_sel = 0; m_bc = 0; m_phase = 1'b0;
    sb.delete();
  endtask

  task automatic check(input string tag, input exp_t e);
    exp_t got;
    got = '{an: an, seg: seg, dp: dp};
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
             tag, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
    end
    vectors++;
    assert ($countones(~an) <= 1) else begin
      miscompares++;
      $error("FAIL %s_onehot: got an=%b, want at most one low anode", tag, an);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    exp_t e;
    sb.push_back(predict());
    model_advance();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, e);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("reset", OFF);
    ncr = 1'b0;

    // 1: plain scan of 1,2,3,4
    en = 1'b1; d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    run("scan", 20);

    // 2: leading-zero blanking on and off
    d3 = 4'd0; lzb = 1'b1;
    run("lzb_on", 16);
    lzb = 1'b0;
    run("lzb_off", 16);

    // 3: blink on slot 0 across several phase toggles
    blink_mask = 4'b0001; d0 = 4'd8;
    run("blink", 32);
    blink_mask = 4'b0000;

    // 4: invalid code dash and decimal point on slot 2
    d1 = 4'hC; dp_mask = 4'b0100;
    run("dash_dp", 16);

    // 5: disable mid-slot 2, hold, resume
    begin
      int guard = 0;
      while (!(m_sel == 2 && m_ps == 1) && guard < 40) begin
        step("seek2");
        guard++;
      end
      vectors++;
      assert (guard < 40) else begin
        miscompares++;
        $error("FAIL seek2_timeout: got %0d cycles, want < 40", guard);
      end
    end
    en = 1'b0;
    run("disabled", 20);
    en = 1'b1;
    run("resume", 16);

    // 6: async reset mid-cycle during slot 1
    begin
      int guard = 0;
      while (m_sel != 1 && guard < 40) begin
        step("seek1");
        guard++;
      end
      vectors++;
      assert (guard < 40) else begin
        miscompares++;
        $error("FAIL seek1_timeout: got %0d cycles, want < 40", guard);
      end
    end
    step("slot1");
    #2 ncr = 1'b1;
    #1 check("async_rst", OFF);
    @(posedge clk);
    #1 check("rst_held", OFF);
    @(negedge clk);
    ncr = 1'b0;
    model_reset();
    run("post_rst", 16);

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      d0 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15));
      d2 = 4'($urandom_range(0, 15));
      d3 = 4'($urandom_range(0, 3));
      lzb = 1'($urandom_range(0, 1));
      blink_mask = 4'($urandom_range(0, 15));
      dp_mask = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumer side of the clock's BCD digit counters.
- Takes four BCD digits (HH:MM, produced by the mod-N counter chain) and time-multiplexes them onto the Basys2 4-digit common-anode 7-segment display.
- Provides scan timing, leading-zero blanking, per-digit blink (for time-set mode) and decimal-point control.
- Sits between the counter chain and the board pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit step (50 MHz gives 1 kHz step, 250 Hz refresh).
- BLINK_DIV, 500, digit steps per blink half-period (0.5 s at defaults).

Ports:
- clk  in  1  system clock.
- ncr  in  1  asynchronous active-high reset.
- en  in  1  display enable; 0 blanks the display and freezes scanning.
- d0  in  4  BCD minutes units (rightmost digit).
- d1  in  4  BCD minutes tens.
- d2  in  4  BCD hours units.
- d3  in  4  BCD hours tens (leftmost digit).
- lzb  in  1  leading-zero blank enable for d3.
- blink_mask  in  4  bit i set: digit i blinks.
- dp_mask  in  4  bit i set: decimal point i lit.
- an  out  4  anode selects, active-low, an[0] = rightmost.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (async, ncr=1):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1.
  - Internal state: prescaler=0, sel=0, blink counter=0, phase=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while en=1.
  - tick asserts for one cycle when count==SCAN_DIV-1; the count wraps to 0 on the same edge.
- Digit select sel[1:0]:
  - Advances on tick, order 0,1,2,3,0.
  - Wraps 3->0 with no idle slot.
- Blink counter:
  - Counts ticks 0..BLINK_DIV-1.
  - On wrap, phase toggles.
- Output registration:
  - an, seg and dp are registered from the current sel and inputs.
  - Latency is 1 clk: a change on the selected digit input appears on seg on the next edge.
  - Inputs are not otherwise sampled, so digits may change at any time.
- Per slot i, when en=1:
  - an = ~(1<<i), except an=4'b1111 when the digit is blanked.
  - Blanked when (blink_mask[i] & phase), or when (i==3 & lzb & d3==0).
  - seg = decode(di); 7'b1111111 while blanked.
  - dp = ~dp_mask[i]; dp=1 while blanked.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Invalid 10..15 shows a dash: 0111111.
- en=0:
  - From the next edge: an=1111, seg=1111111, dp=1.
  - Prescaler, sel, blink counter and phase hold.
  - On re-enable, scanning resumes from the held values.
- Simultaneous events:
  - tick coinciding with the blink wrap: sel advances and phase toggles on the same edge, and the new slot uses the old phase (registered).
  - ncr during any state forces the reset values immediately; no partial frame is emitted after release.
- Never more than one anode low in any cycle.

Decomposition:
- Header seg7_defs.vh holds:
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Anode constant AN_OFF.
- Sub-module bcd_to_seg7:
  - Combinational; 4-bit BCD in, 7-bit active-low pattern out.
  - Reused later by the alarm/date display.
- Top level holds the prescaler, sel, blink logic and output registers.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
1. Reset, then en=1, d3..d0=1,2,3,4, masks=0, lzb=0 -> an cycles 1110,1101,1011,0111 every 4 clk; seg 0011001,0110000,0100100,1111001 respectively; dp=1 throughout.
2. d3=0, lzb=1 -> slot 3 shows an=1111, seg=1111111. With lzb=0 the same slot shows an=0111, seg=1000000.
3. blink_mask=0001, d0=8 -> slot 0 shows seg=0000000 while phase=0 and is blanked (an=1111) while phase=1; phase toggles every 8 clk; other slots are unaffected.
4. d1=4'hC -> slot 1 seg=0111111. dp_mask=0100 -> dp=0 only in slot 2.
5. Deassert en mid-slot 2 -> next clk an=1111; hold 20 clk; re-assert -> slot 2 resumes and completes its remaining count before sel advances to 3.
6. Assert ncr asynchronously mid-cycle during slot 1 -> an=1111, seg=1111111, dp=1 before the next edge. After release, the first slot is 0 after 4 clk.
